// File: rtl/dequant_pkg.sv
// Shared widths and clamp limits for the dequantization datapath.
package dequant_pkg;

    localparam int unsigned Q_W     = 8;
    localparam int unsigned ACC_W   = 24;
    localparam int unsigned SCALE_W = 16;
    localparam int unsigned SHIFT_W = 4;

    // Product of (q - zp) and scale, and that product after the maximum left shift.
    localparam int unsigned PROD_W  = Q_W + SCALE_W + 1;
    localparam int unsigned SHL_W   = PROD_W + (2 ** SHIFT_W) - 1;

    localparam logic signed [SHL_W-1:0] ACC_MAX = SHL_W'((64'sd1 <<< (ACC_W - 1)) - 64'sd1);
    localparam logic signed [SHL_W-1:0] ACC_MIN = ~ACC_MAX;

endpackage

// File: rtl/dequant_saturate.sv
// Combinational clamp of the shifted product into the signed accumulator range.
module dequant_saturate
    import dequant_pkg::*;
(
    input  logic signed [SHL_W-1:0] value,
    output logic        [ACC_W-1:0] result,
    output logic                    clamped
);

    always_comb begin
        result  = ACC_W'(value);
        clamped = 1'b0;
        if (value > ACC_MAX) begin
            result  = ACC_W'(ACC_MAX);
            clamped = 1'b1;
        end else if (value < ACC_MIN) begin
            result  = ACC_W'(ACC_MIN);
            clamped = 1'b1;
        end
    end

endmodule

// File: rtl/dequantization_unit.sv
// Two-stage valid/ready dequantizer: (q - zp) * scale <<< shift, clamped to ACC_W.
// Optional sticky saturation flag enabled by DEQUANT_SAT_FLAG_EN.
module dequantization_unit
    import dequant_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_load,
    input  logic [SCALE_W-1:0] cfg_scale,
    input  logic [Q_W-1:0]     cfg_zero_point,
    input  logic [SHIFT_W-1:0] cfg_shift,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [Q_W-1:0]     in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ACC_W-1:0]   out_data
`ifdef DEQUANT_SAT_FLAG_EN
    ,
    output logic               sat_flag
`endif
);

    logic [SCALE_W-1:0] scale_q;
    logic [Q_W-1:0]     zp_q;
    logic [SHIFT_W-1:0] shift_q;

    logic                     advance;
    logic signed [PROD_W-1:0] diff_c;
    logic signed [PROD_W-1:0] scale_c;
    logic signed [PROD_W-1:0] prod_c;

    logic                     s1_valid;
    logic signed [PROD_W-1:0] s1_prod;
    logic [SHIFT_W-1:0]       s1_shift;

    logic signed [SHL_W-1:0]  shifted_c;
    logic [ACC_W-1:0]         sat_data_c;
    logic                     clamped_c;

    // Whole pipeline moves together whenever the output slot is free or being drained.
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance;

    // Zero-extended operands keep the 25-bit signed product exact.
    assign diff_c  = $signed(PROD_W'(in_data)) - $signed(PROD_W'(zp_q));
    assign scale_c = $signed(PROD_W'(scale_q));
    assign prod_c  = diff_c * scale_c;

    // Config resets to identity so an unconfigured unit passes q straight through.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scale_q <= SCALE_W'(1);
            zp_q    <= '0;
            shift_q <= '0;
        end else if (cfg_load) begin
            scale_q <= cfg_scale;
            zp_q    <= cfg_zero_point;
            shift_q <= cfg_shift;
        end
    end

    // Stage 1: product plus the shift that belongs to this beat's config.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_prod  <= '0;
            s1_shift <= '0;
        end else if (advance) begin
            s1_valid <= in_valid;
            s1_prod  <= prod_c;
            s1_shift <= shift_q;
        end
    end

    assign shifted_c = SHL_W'(s1_prod) <<< s1_shift;

    dequant_saturate u_saturate (
        .value   (shifted_c),
        .result  (sat_data_c),
        .clamped (clamped_c)
    );

    // Stage 2: clamped result held stable while the consumer stalls.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (advance) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= sat_data_c;
            end
        end
    end

`ifdef DEQUANT_SAT_FLAG_EN
    // A clamp landing on the same edge as cfg_load takes priority over the clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_flag <= 1'b0;
        end else if (advance && s1_valid && clamped_c) begin
            sat_flag <= 1'b1;
        end else if (cfg_load) begin
            sat_flag <= 1'b0;
        end
    end
`else
    logic clamped_unused;
    assign clamped_unused = clamped_c;
`endif

endmodule

// File: tb/tb_dequantization_unit.sv
// Scoreboard bench for dequantization_unit: random and directed beats checked against
// an integer reference model; sat_flag checks only when DEQUANT_SAT_FLAG_EN is defined.
module tb_dequantization_unit;
    import dequant_pkg::*;

    logic               clk = 1'b0;
    logic               rst;
    logic               cfg_load;
    logic [SCALE_W-1:0] cfg_scale;
    logic [Q_W-1:0]     cfg_zero_point;
    logic [SHIFT_W-1:0] cfg_shift;
    logic               in_valid;
    logic               in_ready;
    logic [Q_W-1:0]     in_data;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_data;
`ifdef DEQUANT_SAT_FLAG_EN
    logic               sat_flag;
`endif

    always #5 clk = ~clk;

    dequantization_unit dut (
        .clk            (clk),
        .rst            (rst),
        .cfg_load       (cfg_load),
        .cfg_scale      (cfg_scale),
        .cfg_zero_point (cfg_zero_point),
        .cfg_shift      (cfg_shift),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data)
`ifdef DEQUANT_SAT_FLAG_EN
        ,
        .sat_flag       (sat_flag)
`endif
    );

    typedef struct {
        logic [ACC_W-1:0] data;
        bit               clamped;
    } exp_t;

    exp_t             exp_q[$];
    logic [ACC_W-1:0] got_q[$];
    int               n_cmp = 0;
    int               n_err = 0;
    int               m_scale = 1;
    int               m_zp = 0;
    int               m_shift = 0;
    bit               sat_seen = 1'b0;
    int               rdy_mode = 0;

    // Reference: exact integer arithmetic, then clamp to the signed 24-bit range.
    function automatic exp_t model(input int q, input int sc, input int zp, input int sh);
        exp_t   e;
        longint v;
        v = longint'(q - zp) * longint'(sc);
        v = v * (longint'(1) << sh);
        e.clamped = 1'b0;
        if (v > 64'sd8388607) begin
            v = 64'sd8388607;
            e.clamped = 1'b1;
        end else if (v < -64'sd8388608) begin
            v = -64'sd8388608;
            e.clamped = 1'b1;
        end
        e.data = ACC_W'(v);
        return e;
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_got(input string name, input int idx, input int v);
        logic [ACC_W-1:0] ev;
        ev = ACC_W'(v);
        if (idx < got_q.size()) begin
            check(name, longint'(got_q[idx]), longint'(ev));
        end else begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: got no output expected 0x%0h", name, ev);
        end
    endtask

    // Consumer: always ready, random, or stalled, changing just after each edge.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (rdy_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'($urandom_range(0, 1));
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor: inspects the cycle ahead of each edge, pops on every output transfer.
    exp_t             mon_e;
    logic [ACC_W-1:0] held;
    bit               was_stall = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            check("in_ready", longint'(in_ready), longint'(!out_valid || out_ready));
            if (was_stall) begin
                check("stall_valid", longint'(out_valid), 64'd1);
                check("stall_data", longint'(out_data), longint'(held));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_out: got 0x%0h expected no beat", out_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", longint'(out_data), longint'(mon_e.data));
                    if (mon_e.clamped) sat_seen = 1'b1;
                    got_q.push_back(out_data);
                end
            end
            was_stall = out_valid && !out_ready;
            held      = out_data;
        end else begin
            was_stall = 1'b0;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Offer one beat (optionally with cfg_load on its first edge) until accepted.
    task automatic send(input int q, input bit wc = 1'b0, input int sc = 1,
                        input int zp = 0, input int sh = 0);
        bit acc;
        bit first;
        first    = 1'b1;
        in_valid = 1'b1;
        in_data  = Q_W'(q);
        if (wc) begin
            cfg_load       = 1'b1;
            cfg_scale      = SCALE_W'(sc);
            cfg_zero_point = Q_W'(zp);
            cfg_shift      = SHIFT_W'(sh);
        end
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            if (acc) exp_q.push_back(model(q, m_scale, m_zp, m_shift));
            if (first && wc) begin
                m_scale  = sc;
                m_zp     = zp;
                m_shift  = sh;
                sat_seen = 1'b0;
            end
            first = 1'b0;
            #1;
            cfg_load = 1'b0;
            if (acc) begin
                in_valid = 1'b0;
                return;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        n_err++;
        $display("FAIL send_timeout: got in_ready=0 for 200 cycles expected acceptance");
    endtask

    task automatic cfg(input int sc, input int zp, input int sh);
        cfg_load       = 1'b1;
        cfg_scale      = SCALE_W'(sc);
        cfg_zero_point = Q_W'(zp);
        cfg_shift      = SHIFT_W'(sh);
        @(posedge clk);
        m_scale  = sc;
        m_zp     = zp;
        m_shift  = sh;
        sat_seen = 1'b0;
        #1;
        cfg_load = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < 500) begin
            @(posedge clk);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish before 500000");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        rst            = 1'b0;
        cfg_load       = 1'b0;
        cfg_scale      = '0;
        cfg_zero_point = '0;
        cfg_shift      = '0;
        in_valid       = 1'b0;
        in_data        = '0;
        out_ready      = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_out_valid", longint'(out_valid), 64'd0);
        check("rst_out_data", longint'(out_data), 64'd0);
        check("rst_in_ready", longint'(in_ready), 64'd1);
`ifdef DEQUANT_SAT_FLAG_EN
        check("rst_sat_flag", longint'(sat_flag), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;

        // Identity config and two-cycle latency
        got_q.delete();
        in_valid = 1'b1;
        in_data  = 8'd100;
        @(negedge clk);
        check("lat_in_ready", longint'(in_ready), 64'd1);
        @(posedge clk);
        exp_q.push_back(model(100, m_scale, m_zp, m_shift));
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("lat_n1_valid", longint'(out_valid), 64'd0);
        @(negedge clk);
        check("lat_n2_valid", longint'(out_valid), 64'd1);
        check("lat_n2_data", longint'(out_data), 64'd100);
        drain();

        // Scale 3, zero point 128, shift 2
        got_q.delete();
        cfg(3, 128, 2);
        send(200);
        send(0);
        send(128);
        drain();
        check_got("cfg_200", 0, 864);
        check_got("cfg_0", 1, -1536);
        check_got("cfg_128", 2, 0);

        // Saturation at both ends
        got_q.delete();
        cfg(65535, 0, 15);
        send(255);
        drain();
        check_got("sat_max", 0, 8388607);
`ifdef DEQUANT_SAT_FLAG_EN
        check("sat_flag_max", longint'(sat_flag), longint'(sat_seen));
        check("sat_flag_max_set", longint'(sat_flag), 64'd1);
`endif
        cfg(65535, 255, 15);
        send(0);
        drain();
        check_got("sat_min", 1, -8388608);
        cfg(1, 0, 0);
`ifdef DEQUANT_SAT_FLAG_EN
        check("sat_flag_clear", longint'(sat_flag), 64'd0);
`endif

        // Backpressure mid-stream
        got_q.delete();
        rdy_mode = 0;
        send(10);
        send(20);
        fork
            begin
                send(30);
                send(40);
            end
            begin
                rdy_mode = 2;
                repeat (3) @(posedge clk);
                rdy_mode = 0;
            end
        join
        drain();
        check_got("bp_0", 0, 10);
        check_got("bp_1", 1, 20);
        check_got("bp_2", 2, 30);
        check_got("bp_3", 3, 40);
        check("bp_count", longint'(got_q.size()), 64'd4);

        // Config change between beats, then cfg_load on the accepting edge
        got_q.delete();
        send(50);
        cfg(2, 0, 0);
        send(50);
        send(7, 1'b1, 5, 0, 0);
        send(7);
        drain();
        check_got("mid_old", 0, 50);
        check_got("mid_new", 1, 100);
        check_got("same_edge_old", 2, 14);
        check_got("same_edge_new", 3, 35);

        // Randomised traffic, configs and consumer stalls
        rdy_mode = 1;
        for (int i = 0; i < 300; i++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (r == 0)
                cfg(int'($urandom_range(0, 65535)), int'($urandom_range(0, 255)),
                    int'($urandom_range(0, 15)));
            else if (r == 1)
                send(int'($urandom_range(0, 255)), 1'b1, int'($urandom_range(0, 65535)),
                     int'($urandom_range(0, 255)), int'($urandom_range(0, 15)));
            else if (r == 2)
                idle(1);
            else
                send(int'($urandom_range(0, 255)));
        end
        rdy_mode = 0;
        drain();

        // Reset with beats in flight
        cfg(3, 10, 4);
        send(11);
        send(22);
        #1 rst = 1'b0;
        #1;
        check("mrst_out_valid", longint'(out_valid), 64'd0);
        check("mrst_in_ready", longint'(in_ready), 64'd1);
        exp_q.delete();
        m_scale  = 1;
        m_zp     = 0;
        m_shift  = 0;
        sat_seen = 1'b0;
`ifdef DEQUANT_SAT_FLAG_EN
        check("mrst_sat_flag", longint'(sat_flag), 64'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b1;
        got_q.delete();
        idle(6);
        send(77);
        drain();
        check_got("mrst_identity", 0, 77);
        check("mrst_count", longint'(got_q.size()), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
